// File: rtl/instr_mem_responder.sv
// Instruction memory responder: single-port 16-bit word array with fixed
// request-to-response latency, stall while busy, and error reporting for
// unaligned or conflicting (rd+wr) requests.
module instr_mem_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;

    // Latched request, captured on the acceptance edge
    logic [AW:0]    req_addr, req_addr_n;
    logic           req_rd, req_rd_n;
    logic           req_wr, req_wr_n;
    logic [DW-1:0]  req_data, req_data_n;

    logic [DW-1:0]  data_out_n;
    logic           done_n, stall_n, err_n;

    // Request that completes on this edge (inputs when LATENCY=1, else latched)
    logic [AW:0]    src_addr;
    logic           src_rd, src_wr;
    logic [DW-1:0]  src_data;
    logic           finish;

    logic           mem_we;
    logic [AW-1:0]  mem_idx;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem [DEPTH];

    // Address bits above the word index are intentionally ignored (wrap)
    logic           unused_addr_bits;
    assign unused_addr_bits = ^(addr >> (AW + 1));

    // Next-state, request latching, completion and registered-output values
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_addr_n = req_addr;
        req_rd_n   = req_rd;
        req_wr_n   = req_wr;
        req_data_n = req_data;
        data_out_n = data_out;
        done_n     = 1'b0;
        stall_n    = 1'b0;
        err_n      = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;
        src_addr   = req_addr;
        src_rd     = req_rd;
        src_wr     = req_wr;
        src_data   = req_data;
        finish     = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (rd || wr) begin
                    req_addr_n = addr[AW:0];
                    req_rd_n   = rd;
                    req_wr_n   = wr;
                    req_data_n = data_in;
                    if (LATENCY == 1) begin
                        finish   = 1'b1;
                        src_addr = addr[AW:0];
                        src_rd   = rd;
                        src_wr   = wr;
                        src_data = data_in;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CW'(LATENCY - 32'd2);
                        stall_n = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish = 1'b1;
                end else begin
                    cnt_n   = cnt - CW'(1);
                    stall_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (finish) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = (src_rd && src_wr) || src_addr[0];
            if (src_rd && !src_wr) begin
                data_out_n = src_addr[0] ? DW'(0) : mem[src_addr[AW:1]];
            end
            if (src_wr && !err_n) begin
                mem_we    = 1'b1;
                mem_idx   = src_addr[AW:1];
                mem_wdata = src_data;
            end
        end
    end

    // State, counter, latched request and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_addr <= '0;
            req_rd   <= 1'b0;
            req_wr   <= 1'b0;
            req_data <= '0;
            data_out <= '0;
            done     <= 1'b0;
            stall    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            req_addr <= req_addr_n;
            req_rd   <= req_rd_n;
            req_wr   <= req_wr_n;
            req_data <= req_data_n;
            data_out <= data_out_n;
            done     <= done_n;
            stall    <= stall_n;
            err      <= err_n;
        end
    end

    // Memory array: not cleared by reset; a reset edge suppresses the commit
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 3) share one request bus.
module tb_instr_mem_responder;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] data_in;
    logic [15:0] dout2, dout3;
    logic        done2, done3, stall2, stall3, err2, err3;

    int          n_checks = 0;
    int          n_errors = 0;

    exp_t        q2[$];
    exp_t        q3[$];
    exp_t        pop2, pop3;
    logic [15:0] model [256];
    logic [15:0] last2, last3;
    logic        mon2_en, mon3_en;

    instr_mem_responder #(.LATENCY(2), .AW(8)) u_dut2 (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
        .data_out(dout2), .done(done2), .stall(stall2), .err(err2)
    );

    instr_mem_responder #(.LATENCY(3), .AW(8)) u_dut3 (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
        .data_out(dout3), .done(done3), .stall(stall3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: every done pops the scoreboard; err must never lead done
    always @(negedge clk) begin
        if (mon2_en) begin
            if (done2) begin
                if (q2.size() == 0) chk("L2 unexpected done", 32'(done2), 32'd0);
                else begin
                    pop2 = q2.pop_front();
                    chk("L2 data_out", 32'(dout2), 32'(pop2.d));
                    chk("L2 err", 32'(err2), 32'(pop2.e));
                end
            end else chk("L2 err without done", 32'(err2), 32'd0);
        end
        if (mon3_en) begin
            if (done3) begin
                if (q3.size() == 0) chk("L3 unexpected done", 32'(done3), 32'd0);
                else begin
                    pop3 = q3.pop_front();
                    chk("L3 data_out", 32'(dout3), 32'(pop3.d));
                    chk("L3 err", 32'(err3), 32'(pop3.e));
                end
            end else chk("L3 err without done", 32'(err3), 32'd0);
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " L2 data_out"}, 32'(dout2), 32'd0);
        chk({tag, " L2 done"}, 32'(done2), 32'd0);
        chk({tag, " L2 stall"}, 32'(stall2), 32'd0);
        chk({tag, " L2 err"}, 32'(err2), 32'd0);
        chk({tag, " L3 data_out"}, 32'(dout3), 32'd0);
        chk({tag, " L3 done"}, 32'(done3), 32'd0);
        chk({tag, " L3 stall"}, 32'(stall3), 32'd0);
        chk({tag, " L3 err"}, 32'(err3), 32'd0);
    endtask

    // One-cycle request from a negedge; checks stall/done timing for both latencies
    task automatic do_req(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        logic        e;
        logic [15:0] v;
        logic [7:0]  idx;
        idx = a[8:1];
        e   = (r && w) || a[0];
        v   = (r && !w) ? (a[0] ? 16'h0000 : model[idx]) : last2;
        last2 = v;
        q2.push_back('{d: v, e: e});
        v   = (r && !w) ? (a[0] ? 16'h0000 : model[idx]) : last3;
        last3 = v;
        q3.push_back('{d: v, e: e});
        if (w && !r && !a[0]) model[idx] = d;
        addr = a; rd = r; wr = w; data_in = d;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin rd = 1'b0; wr = 1'b0; end
            chk($sformatf("L2 stall c%0d", c), 32'(stall2), 32'(c < 2));
            chk($sformatf("L2 done c%0d", c), 32'(done2), 32'(c == 2));
            chk($sformatf("L3 stall c%0d", c), 32'(stall3), 32'(c < 3));
            chk($sformatf("L3 done c%0d", c), 32'(done3), 32'(c == 3));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last2 = 16'h0000;
        last3 = 16'h0000;
    endtask

    initial begin
        mon2_en = 1'b0; mon3_en = 1'b0;
        rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;
        last2 = '0; last3 = '0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        mon2_en = 1'b1; mon3_en = 1'b1;

        // Basic write then read
        do_req(16'h0010, 1'b0, 1'b1, 16'hBEEF);
        do_req(16'h0010, 1'b1, 1'b0, 16'h0000);

        // Preload
        do_req(16'h0000, 1'b0, 1'b1, 16'h1111);
        do_req(16'h0002, 1'b0, 1'b1, 16'h2222);
        do_req(16'h0030, 1'b0, 1'b1, 16'h1234);
        do_req(16'h0020, 1'b0, 1'b1, 16'h9999);
        do_req(16'h0010, 1'b1, 1'b0, 16'h0000);

        // Unaligned read, then the neighbouring word is untouched
        do_req(16'h0013, 1'b1, 1'b0, 16'h0000);
        do_req(16'h0012, 1'b0, 1'b1, 16'h4242);
        do_req(16'h0013, 1'b1, 1'b0, 16'h0000);
        do_req(16'h0012, 1'b1, 1'b0, 16'h0000);
        do_req(16'h0010, 1'b1, 1'b0, 16'h0000);

        // rd and wr together: error, no write, data_out held
        do_req(16'h0020, 1'b1, 1'b1, 16'h5555);
        do_req(16'h0020, 1'b1, 1'b0, 16'h0000);

        // Address wrap above AW
        do_req(16'h0204, 1'b0, 1'b1, 16'hA5A5);
        do_req(16'h0004, 1'b1, 1'b0, 16'h0000);

        // Unaligned write is not committed
        do_req(16'h0031, 1'b0, 1'b1, 16'hFFFF);
        do_req(16'h0030, 1'b1, 1'b0, 16'h0000);

        // Sustained reads on the LATENCY=3 responder
        mon2_en = 1'b0;
        q3.push_back('{d: 16'h1111, e: 1'b0});
        q3.push_back('{d: 16'h2222, e: 1'b0});
        last3 = 16'h2222;
        addr = 16'h0000; rd = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("L3 burst stall c%0d", c), 32'(stall3), 32'((c % 3) != 0));
            chk($sformatf("L3 burst done c%0d", c), 32'(done3), 32'((c % 3) == 0));
            if (c == 3) addr = 16'h0002;
            if (c == 6) rd = 1'b0;
        end
        repeat (4) @(negedge clk);
        pulse_reset();
        chk_outputs_zero("post-burst reset");
        q2.delete();
        mon2_en = 1'b1;

        // Reset during BUSY of a write aborts it
        addr = 16'h0030; data_in = 16'h7777; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        pulse_reset();
        chk_outputs_zero("abort reset");
        repeat (4) @(negedge clk);
        do_req(16'h0030, 1'b1, 1'b0, 16'h0000);

        // Request coinciding with reset is dropped
        addr = 16'h0010; rd = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd = 1'b0;
        last2 = 16'h0000; last3 = 16'h0000;
        chk_outputs_zero("reset with request");
        repeat (4) @(negedge clk);

        // Randomised traffic over a small preloaded window
        for (int i = 0; i < 8; i++)
            do_req(16'(16'h0040 + 2 * i), 1'b0, 1'b1, 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            do_req(16'(16'h0040 + $urandom_range(0, 15)), op[0], op[1], 16'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("L2 scoreboard drained", 32'(q2.size()), 32'd0);
        chk("L3 scoreboard drained", 32'(q3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: clock edges from request acceptance to response; legal range 1..15.
REQ-002 Parameter AW, default 8: word-address width; array holds 2^AW 16-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 addr  input  16  byte address of the request; word index = addr[AW:1].
REQ-006 rd  input  1  read request (fetch side).
REQ-007 wr  input  1  write request (image load / self-test).
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data, registered.
REQ-010 done  output  1  one-cycle response pulse.
REQ-011 stall  output  1  request in flight; requester holds addr/rd.
REQ-012 err  output  1  error flag, valid only with done.

Function
REQ-013 States: IDLE, BUSY, DONE; a 4-bit down-counter tracks BUSY cycles.
REQ-014 Acceptance: rd or wr sampled high on an edge while in IDLE or DONE.
- addr, rd, wr, and data_in are latched into request registers at that edge.
REQ-015 Read timing:
- Count the acceptance edge as edge 1.
- done is high for exactly the one cycle following edge LATENCY.
- data_out = mem[latched word index] in that cycle.
REQ-016 stall is high in every cycle between acceptance and the done cycle: LATENCY-1 cycles, so never high when LATENCY=1.
- stall is low in IDLE and in DONE.
REQ-017 Writes use the same timing.
- mem[latched index] <= latched data_in on edge LATENCY.
- done pulses in the following cycle.
- data_out is unchanged by a write.
REQ-018 data_out holds its last read value until the next read's done cycle.
REQ-019 Requests sampled while in BUSY are ignored.
- They are not queued, and they do not disturb the latched request.
REQ-020 Back-to-back requests are allowed.
- A request sampled in the DONE cycle is accepted.
- That gives one response per LATENCY cycles of sustained throughput.
REQ-021 DONE with no new request returns to IDLE on the next edge.
REQ-022 rd and wr both high at acceptance:
- The request is accepted and follows normal timing.
- No memory access occurs.
- done and err are both high in the response cycle.
- data_out is unchanged.
REQ-023 Unaligned request (latched addr[0]=1):
- No memory access occurs.
- done and err are both high in the response cycle.
- For a read, data_out = 16'h0000.
REQ-024 Address bits above AW are ignored; addresses wrap modulo 2^(AW+1) bytes.
REQ-025 err is low whenever done is low.

Reset
REQ-026 When rst is high at an edge:
- state = IDLE, counter = 0.
- done = 0, stall = 0, err = 0, data_out = 16'h0000.
REQ-027 Reset during BUSY aborts the request: no done is produced, and no write is committed.
REQ-028 Memory array contents are not cleared by reset.
REQ-029 A request sampled on the same edge as reset is discarded.
- The first acceptance is possible on the edge after rst deasserts.

Verification
REQ-030 LATENCY=2: write 16'hBEEF @ 0x0010, then read 0x0010.
- Read: stall high 1 cycle, then done=1 and data_out=16'hBEEF for exactly 1 cycle, err=0.
REQ-031 LATENCY=3: rd held high continuously at addr 0x0000 then 0x0002, containing 16'h1111 and 16'h2222.
- done pulses every 3 cycles with 16'h1111 then 16'h2222.
- stall is high 2 of every 3 cycles.
REQ-032 Read at addr 0x0013 -> done=1, err=1, data_out=16'h0000; no array entry changes.
REQ-033 rd=wr=1 at 0x0020 with data_in=16'h5555 -> done=1, err=1; a later read of 0x0020 returns the prior value.
REQ-034 AW=8: write 16'hA5A5 @ 0x0204, then read 0x0004 -> 16'hA5A5 (wrap).
REQ-035 Reset mid-operation: assert rst during BUSY of a write of 16'h7777 @ 0x0030.
- No done follows.
- A later read of 0x0030 returns the old value.
- All outputs read 0 the cycle after reset.
